// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, width helpers and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Single conditional subtract is enough because callers never exceed 2*n-1.
  function automatic int wrap(input int a, input int n);
    return a >= n ? a - n : a;
  endfunction
  localparam int NUM_REQ_DEF = 4;
  localparam int BURST_LEN_DEF = 4;
  localparam int GID_W = idx_w(NUM_REQ_DEF);
  localparam int CNT_W = $clog2(BURST_LEN_DEF + 1);
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search for the first set request after last_grant.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic         any_req,
  output logic [W-1:0] pick_idx
);
  // Walk from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    any_req = |req;
    pick_idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[wrap(int'(last_grant) + k, N)]) pick_idx = W'(wrap(int'(last_grant) + k, N));
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [idx_w(NUM_REQ)-1:0]     grant_id,
  output logic                          busy
);
  localparam int GW = idx_w(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN + 1);
  state_t state, state_nx;
  logic [GW-1:0] last_grant, pick_idx;
  logic [CW-1:0] beat_cnt;
  logic any_req, accept, rel;
  rr_picker #(.N(NUM_REQ)) u_pick (
    .req       (req_valid),
    .last_grant(last_grant),
    .any_req   (any_req),
    .pick_idx  (pick_idx)
  );
  // Strobe, ready and data are combinational so a beat can move in the first granted cycle.
  always_comb begin
    busy = state == GRANT;
    accept = busy & req_valid[grant_id] & ~fifo_full;
    rel = busy & (~req_valid[grant_id] | (accept & (beat_cnt == CW'(BURST_LEN - 1))));
    fifo_wr = accept;
    req_ready = (busy & ~fifo_full) ? NUM_REQ'(1) << grant_id : '0;
    fifo_wr_data = busy ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    state_nx = busy ? (rel ? IDLE : GRANT) : (any_req ? GRANT : IDLE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      state <= state_nx;
      if (!busy && any_req) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
      end
      if (rel) last_grant <= grant_id;
      else if (accept) beat_cnt <= beat_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, directed corner sequences and randomized reference-model checks.
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, BL = 4;
  logic clk = 0, reset = 1, fifo_full = 0;
  logic [N-1:0] req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic fifo_wr, busy;
  logic [DW-1:0] fifo_wr_data;
  logic [1:0] grant_id;
  int checks = 0, errors = 0;
  bit m_busy;
  int m_g, m_cnt, m_last;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1;
    req_valid = '0;
    fifo_full = 0;
    cyc();
    reset = 0;
    m_busy = 0; m_g = 0; m_cnt = 0; m_last = N - 1;
  endtask

  // Reference model: outputs from the granted requester, grant chosen by scanning (last+k)%N.
  task automatic m_check;
    bit ew;
    ew = m_busy && req_valid[m_g] && !fifo_full;
    chk("rnd_busy", 32'(busy), 32'(m_busy));
    chk("rnd_wr", 32'(fifo_wr), 32'(ew));
    chk("rnd_ready", 32'(req_ready), (m_busy && !fifo_full) ? 32'(1) << m_g : 32'd0);
    chk("rnd_data", 32'(fifo_wr_data), m_busy ? 32'(req_data[m_g*DW +: DW]) : 32'd0);
    if (m_busy) chk("rnd_gid", 32'(grant_id), 32'(m_g));
  endtask

  task automatic m_edge;
    bit ew;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++)
        if (req_valid[(m_last + k) % N]) begin
          m_g = (m_last + k) % N; m_busy = 1; m_cnt = 0;
          break;
        end
    end else begin
      ew = req_valid[m_g] && !fifo_full;
      if (ew) m_cnt++;
      if ((ew && m_cnt == BL) || !req_valid[m_g]) begin
        m_busy = 0; m_last = m_g;
      end
    end
  endtask

  typedef struct {
    logic [3:0] v; logic f; logic b; logic [1:0] g; logic w; logic [3:0] r; logic [7:0] d;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int order[$], wrs[$], gap, ptr[2], fcnt, hs, nx[2], s, stage;
    logic [7:0] rec[$];
    bit pb;
    tbl[0]  = '{4'b0110, 0, 0, 0, 0, 4'b0000, 8'h00};
    tbl[1]  = '{4'b0110, 0, 1, 1, 1, 4'b0010, 8'h22};
    tbl[2]  = '{4'b0110, 1, 1, 1, 0, 4'b0000, 8'h22};
    tbl[3]  = '{4'b0110, 0, 1, 1, 1, 4'b0010, 8'h22};
    tbl[4]  = '{4'b0100, 0, 1, 1, 0, 4'b0010, 8'h22};
    tbl[5]  = '{4'b0100, 0, 0, 1, 0, 4'b0000, 8'h00};
    tbl[6]  = '{4'b0100, 0, 1, 2, 1, 4'b0100, 8'h33};
    tbl[7]  = '{4'b0100, 0, 1, 2, 1, 4'b0100, 8'h33};
    tbl[8]  = '{4'b0100, 0, 1, 2, 1, 4'b0100, 8'h33};
    tbl[9]  = '{4'b0100, 0, 1, 2, 1, 4'b0100, 8'h33};
    tbl[10] = '{4'b0100, 0, 0, 2, 0, 4'b0000, 8'h00};
    tbl[11] = '{4'b0100, 0, 1, 2, 1, 4'b0100, 8'h33};
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    do_reset();
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wr", 32'(fifo_wr), 0);
    chk("rst_data", 32'(fifo_wr_data), 0);
    cyc();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].v; fifo_full = tbl[i].f;
      #1;
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("tbl%0d_gid", i), 32'(grant_id), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_wr", i), 32'(fifo_wr), 32'(tbl[i].w));
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_data", i), 32'(fifo_wr_data), 32'(tbl[i].d));
      cyc();
    end

    // All four requesters continuously valid: strict rotation, full bursts, one-cycle bubbles.
    do_reset();
    req_valid = 4'b1111; gap = 0; pb = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (busy && !pb) begin
        order.push_back(int'(grant_id)); wrs.push_back(0);
        chk("fair_bubble", 32'(gap), 1);
        gap = 0;
      end
      if (!busy) gap++;
      if (fifo_wr) wrs[wrs.size()-1]++;
      pb = busy;
      cyc();
    end
    chk("fair_grants", 32'(order.size() >= 5), 1);
    for (int i = 0; i < 5 && i < order.size(); i++) chk($sformatf("fair_order%0d", i), 32'(order[i]), 32'(i % N));
    for (int i = 0; i < 4 && i < wrs.size(); i++) chk($sformatf("fair_wrs%0d", i), 32'(wrs[i]), BL);

    // Full stall after two beats: grant held, remaining two beats complete afterwards.
    do_reset();
    req_valid = 4'b0001;
    cyc(); cyc(); cyc();
    fifo_full = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_wr", 32'(fifo_wr), 0);
      chk("stall_ready", 32'(req_ready), 0);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_gid", 32'(grant_id), 0);
      cyc();
    end
    fifo_full = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("stall_resume_wr", 32'(fifo_wr), 1);
      cyc();
    end
    #1;
    chk("stall_release", 32'(busy), 0);

    // Early drop by requester 2: next grant goes to 3, not 0.
    do_reset();
    req_valid = 4'b0100;
    cyc();
    #1;
    chk("drop_gid", 32'(grant_id), 2);
    chk("drop_wr", 32'(fifo_wr), 1);
    cyc();
    req_valid = 4'b1001;
    #1;
    chk("drop_busy", 32'(busy), 1);
    cyc();
    #1;
    chk("drop_idle", 32'(busy), 0);
    cyc();
    #1;
    chk("drop_next_gid", 32'(grant_id), 3);
    chk("drop_next_busy", 32'(busy), 1);

    // Asynchronous reset between edges during a grant.
    do_reset();
    req_valid = 4'b1111;
    cyc(); cyc(); cyc();
    #2 reset = 1;
    #1;
    chk("arst_wr", 32'(fifo_wr), 0);
    chk("arst_ready", 32'(req_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_gid", 32'(grant_id), 0);
    #1 reset = 0;
    cyc(); cyc();
    #1;
    chk("arst_regrant_busy", 32'(busy), 1);
    chk("arst_regrant_gid", 32'(grant_id), 0);

    // End to end with a depth-8 FIFO that is not read until the writer stalls.
    do_reset();
    ptr[0] = 0; ptr[1] = 0; fcnt = 0; hs = 0; stage = 0;
    for (int c = 0; c < 200 && rec.size() < 16; c++) begin
      req_valid = {2'b00, ptr[1] < 8, ptr[0] < 8};
      req_data = '0;
      req_data[7:0] = 8'(ptr[0]);
      req_data[15:8] = 8'(8'h10 + ptr[1]);
      fifo_full = fcnt == 8;
      #1;
      if (fifo_wr) begin rec.push_back(fifo_wr_data); fcnt++; end
      for (int i = 0; i < 2; i++) if (req_valid[i] && req_ready[i]) begin ptr[i]++; hs++; end
      if (stage == 0 && c == 40) begin
        chk("e2e_first_fill", 32'(rec.size()), 8);
        chk("e2e_full", 32'(fifo_full), 1);
        fcnt = 0;
        stage = 1;
      end
      cyc();
    end
    chk("e2e_total", 32'(rec.size()), 16);
    chk("e2e_handshakes", 32'(hs), 16);
    nx[0] = 0; nx[1] = 0;
    foreach (rec[i]) begin
      s = int'(rec[i][7:4]);
      chk("e2e_src", 32'(s < 2), 1);
      if (s < 2) begin
        chk($sformatf("e2e_order_s%0d", s), 32'(rec[i][3:0]), 32'(nx[s]));
        nx[s]++;
      end
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) req_valid = 4'($urandom);
      fifo_full = $urandom_range(3) == 0;
      req_data = 32'($urandom);
      #1;
      m_check();
      m_edge();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
